// File: rtl/pi_pkg.sv
// Shared types, widths and helpers for the priority-interrupt cycle sequencer.
package pi_pkg;

  localparam int NUM_LEVELS = 7;
  localparam int LVL_W      = 3;
  localparam int VEC_W      = 9;
  localparam int CNT_W      = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    CYCLE = 2'd2
  } pi_state_e;

  // Index of the lowest-numbered set bit (level 1 is highest priority), 0 when none.
  function automatic logic [LVL_W-1:0] prio_enc7(input logic [1:NUM_LEVELS] v);
    logic [LVL_W-1:0] idx;
    idx = '0;
    for (int i = NUM_LEVELS; i >= 1; i--) begin
      if (v[i]) idx = LVL_W'(i);
    end
    return idx;
  endfunction

  // Interrupt vector: two locations per level above the base.
  function automatic logic [VEC_W-1:0] pi_vector(input logic [VEC_W-1:0] base,
                                                 input logic [LVL_W-1:0] lvl);
    return base + {{(VEC_W-LVL_W-1){1'b0}}, lvl, 1'b0};
  endfunction

endpackage

// File: rtl/pi_prio_enc.sv
// Combinational 7-bit priority encoder: lowest-numbered set bit wins.
module pi_prio_enc
  import pi_pkg::*;
(
  input  logic [1:NUM_LEVELS] vec_i,
  output logic [LVL_W-1:0]    idx_o,
  output logic                any_o
);

  assign idx_o = prio_enc7(vec_i);
  assign any_o = |vec_i;

endmodule

// File: rtl/pi_cycle_ctl.sv
// Priority-interrupt cycle sequencer: arbitrates PI levels, handshakes a PI
// cycle with the EBOX, inhibits PC+1 during the interrupt instruction, and
// tracks held levels with dismiss.
module pi_cycle_ctl
  import pi_pkg::*;
#(
  parameter logic [VEC_W-1:0] PI_BASE     = 9'o040,
  parameter int               TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pi_on,
  input  logic [1:NUM_LEVELS] pi_req,
  input  logic [1:NUM_LEVELS] en_mask,
  input  logic                ebox_ack,
  input  logic                xct_done,
  input  logic                xct_held,
  input  logic                dismiss,
  output logic                pi_cycle_req,
  output logic                pc_plus1_inh,
  output logic [VEC_W-1:0]    pi_addr,
  output logic [LVL_W-1:0]    pi_level,
  output logic [1:NUM_LEVELS] pi_held,
  output logic                pi_err
);

  pi_state_e           state_q, state_d;
  logic                req_q, req_d;
  logic                inh_q, inh_d;
  logic                err_q, err_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic [VEC_W-1:0]    addr_q, addr_d;
  logic [1:NUM_LEVELS] held_q, held_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [1:NUM_LEVELS] mask_above;
  logic [1:NUM_LEVELS] cand;
  logic [1:NUM_LEVELS] clr_oh;
  logic [1:NUM_LEVELS] set_oh;
  logic [LVL_W-1:0]    win_idx;
  logic [LVL_W-1:0]    held_top;
  logic                cand_any;
  logic                held_any;

  // Highest-priority held level: bounds arbitration and is the dismiss target.
  pi_prio_enc u_held_enc (
    .vec_i (held_q),
    .idx_o (held_top),
    .any_o (held_any)
  );

  // Per-level masks: only levels above the top held level may interrupt;
  // one-hot decodes for the dismiss clear and the hold set.
  for (genvar gi = 1; gi <= NUM_LEVELS; gi++) begin : g_level
    assign mask_above[gi] = ~held_any | (LVL_W'(gi) < held_top);
    assign clr_oh[gi]     = dismiss & (held_top == LVL_W'(gi));
    assign set_oh[gi]     = (level_q == LVL_W'(gi));
  end

  assign cand = pi_on ? (pi_req & en_mask & ~held_q & mask_above) : '0;

  // Winner among eligible requests.
  pi_prio_enc u_win_enc (
    .vec_i (cand),
    .idx_o (win_idx),
    .any_o (cand_any)
  );

  // Next-state and output decode for the IDLE/REQ/CYCLE sequence.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    inh_d   = inh_q;
    err_d   = 1'b0;
    level_d = level_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    // Dismiss acts on the pre-edge held set; a new hold is OR-ed in after.
    held_d  = held_q & ~clr_oh;

    unique case (state_q)
      IDLE: begin
        if (cand_any) begin
          state_d = REQ;
          level_d = win_idx;
          addr_d  = pi_vector(PI_BASE, win_idx);
          req_d   = 1'b1;
        end
      end
      REQ: begin
        // Latched level is frozen here: no pre-emption by later requests.
        if (ebox_ack) begin
          state_d = CYCLE;
          req_d   = 1'b0;
          inh_d   = 1'b1;
          cnt_d   = '0;
        end
      end
      CYCLE: begin
        if (xct_done) begin
          state_d = IDLE;
          inh_d   = 1'b0;
          level_d = '0;
          if (xct_held) held_d = held_d | set_oh;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          // Abort: no hold is recorded for an instruction that never finished.
          state_d = IDLE;
          inh_d   = 1'b0;
          level_d = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
        inh_d   = 1'b0;
        level_d = '0;
      end
    endcase
  end

  // State and output registers; reset abandons any cycle in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      inh_q   <= 1'b0;
      err_q   <= 1'b0;
      level_q <= '0;
      addr_q  <= '0;
      held_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      inh_q   <= inh_d;
      err_q   <= err_d;
      level_q <= level_d;
      addr_q  <= addr_d;
      held_q  <= held_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pi_cycle_req = req_q;
  assign pc_plus1_inh = inh_q;
  assign pi_addr      = addr_q;
  assign pi_level     = level_q;
  assign pi_held      = held_q;
  assign pi_err       = err_q;

endmodule

// File: tb/tb_pi_cycle_ctl.sv
// Scoreboard bench for pi_cycle_ctl: stimulus queues the expected output
// bundle and the cycle it should appear; a monitor pops on every change.
module tb_pi_cycle_ctl;

  typedef struct packed {
    logic       req;
    logic       inh;
    logic [2:0] lvl;
    logic [8:0] addr;
    logic [1:7] held;
    logic       err;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pi_on = 1'b0;
  logic [1:7] pi_req = '0;
  logic [1:7] en_mask = '0;
  logic       ebox_ack = 1'b0;
  logic       xct_done = 1'b0;
  logic       xct_held = 1'b0;
  logic       dismiss = 1'b0;
  logic       pi_cycle_req;
  logic       pc_plus1_inh;
  logic [8:0] pi_addr;
  logic [2:0] pi_level;
  logic [1:7] pi_held;
  logic       pi_err;

  pi_cycle_ctl #(
    .PI_BASE     (9'o040),
    .TIMEOUT_CYC (255)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pi_on        (pi_on),
    .pi_req       (pi_req),
    .en_mask      (en_mask),
    .ebox_ack     (ebox_ack),
    .xct_done     (xct_done),
    .xct_held     (xct_held),
    .dismiss      (dismiss),
    .pi_cycle_req (pi_cycle_req),
    .pc_plus1_inh (pc_plus1_inh),
    .pi_addr      (pi_addr),
    .pi_level     (pi_level),
    .pi_held      (pi_held),
    .pi_err       (pi_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  obs_t  exp_q[$];
  int    due_q[$];
  string name_q[$];
  int    n_tests = 0;
  int    n_fail = 0;

  task automatic expect_out(input string name, input int dly,
                            input logic req, input logic inh,
                            input logic [2:0] lvl, input logic [8:0] addr,
                            input logic [1:7] held, input logic err);
    obs_t o;
    o.req  = req;
    o.inh  = inh;
    o.lvl  = lvl;
    o.addr = addr;
    o.held = held;
    o.err  = err;
    exp_q.push_back(o);
    due_q.push_back((dly < 0) ? -1 : cyc + dly);
    name_q.push_back(name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every change of the output bundle is one transaction.
  obs_t  prev_obs = '1;
  obs_t  cur_obs;
  obs_t  e_obs;
  int    e_due;
  string e_name;
  always @(negedge clk) begin
    cur_obs = {pi_cycle_req, pc_plus1_inh, pi_level, pi_addr, pi_held, pi_err};
    if (cur_obs !== prev_obs) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_change: got req=%b inh=%b lvl=%0d addr=%o held=%b err=%b at cycle %0d, required no change",
                 cur_obs.req, cur_obs.inh, cur_obs.lvl, cur_obs.addr, cur_obs.held, cur_obs.err, cyc);
      end else begin
        e_obs  = exp_q.pop_front();
        e_due  = due_q.pop_front();
        e_name = name_q.pop_front();
        $display("[TB] cycle %0d %s: req=%b inh=%b lvl=%0d addr=%o held=%b err=%b",
                 cyc, e_name, cur_obs.req, cur_obs.inh, cur_obs.lvl, cur_obs.addr, cur_obs.held, cur_obs.err);
        if (cur_obs !== e_obs) begin
          n_fail++;
          $display("FAIL %s: got req=%b inh=%b lvl=%0d addr=%o held=%b err=%b, required req=%b inh=%b lvl=%0d addr=%o held=%b err=%b",
                   e_name, cur_obs.req, cur_obs.inh, cur_obs.lvl, cur_obs.addr, cur_obs.held, cur_obs.err,
                   e_obs.req, e_obs.inh, e_obs.lvl, e_obs.addr, e_obs.held, e_obs.err);
        end
        if (e_due >= 0) begin
          n_tests++;
          if (e_due != cyc) begin
            n_fail++;
            $display("FAIL %s_timing: got cycle %0d, required cycle %0d", e_name, cyc, e_due);
          end
        end
      end
      prev_obs = cur_obs;
    end
  end

  initial begin
    expect_out("reset_state", -1, 0, 0, 3'd0, 9'o000, 7'b0000000, 0);
    repeat (2) step();
    rst_n   = 1'b1;
    step();
    pi_on   = 1'b1;
    en_mask = 7'b1111111;

    // Single level 3 interrupt, held at completion.
    pi_req = 7'b0010000;
    expect_out("l3_req", 1, 1, 0, 3'd3, 9'o046, 7'b0000000, 0);
    step();
    pi_req   = 7'b0000000;
    ebox_ack = 1'b1;
    expect_out("l3_ack", 1, 0, 1, 3'd3, 9'o046, 7'b0000000, 0);
    step();
    ebox_ack = 1'b0;
    repeat (2) step();
    xct_done = 1'b1;
    xct_held = 1'b1;
    expect_out("l3_done_held", 1, 0, 0, 3'd0, 9'o046, 7'b0010000, 0);
    step();
    xct_done = 1'b0;
    xct_held = 1'b0;
    dismiss  = 1'b1;
    expect_out("l3_dismiss", 1, 0, 0, 3'd0, 9'o046, 7'b0000000, 0);
    step();
    dismiss = 1'b0;

    // Levels 2 and 5 together: 2 first, 5 blocked until 2 is dismissed.
    pi_req = 7'b0100100;
    expect_out("l2_wins", 1, 1, 0, 3'd2, 9'o044, 7'b0000000, 0);
    step();
    pi_req   = 7'b0000100;
    ebox_ack = 1'b1;
    expect_out("l2_ack", 1, 0, 1, 3'd2, 9'o044, 7'b0000000, 0);
    step();
    ebox_ack = 1'b0;
    xct_done = 1'b1;
    xct_held = 1'b1;
    expect_out("l2_done_held", 1, 0, 0, 3'd0, 9'o044, 7'b0100000, 0);
    step();
    xct_done = 1'b0;
    xct_held = 1'b0;
    repeat (3) step();
    dismiss = 1'b1;
    expect_out("l2_dismiss", 1, 0, 0, 3'd0, 9'o044, 7'b0000000, 0);
    expect_out("l5_after_dismiss", 2, 1, 0, 3'd5, 9'o052, 7'b0000000, 0);
    step();
    dismiss = 1'b0;
    step();
    pi_req   = 7'b0000000;
    ebox_ack = 1'b1;
    expect_out("l5_ack", 1, 0, 1, 3'd5, 9'o052, 7'b0000000, 0);
    step();
    ebox_ack = 1'b0;
    xct_done = 1'b1;
    expect_out("l5_done_nohold", 1, 0, 0, 3'd0, 9'o052, 7'b0000000, 0);
    step();
    xct_done = 1'b0;

    // Level 4 held, then level 1 nests above it back-to-back; no pre-emption in REQ.
    pi_req = 7'b0001000;
    expect_out("l4_req", 1, 1, 0, 3'd4, 9'o050, 7'b0000000, 0);
    step();
    pi_req   = 7'b1000000;
    ebox_ack = 1'b1;
    expect_out("l4_ack_no_preempt", 1, 0, 1, 3'd4, 9'o050, 7'b0000000, 0);
    step();
    ebox_ack = 1'b0;
    xct_done = 1'b1;
    xct_held = 1'b1;
    expect_out("l4_done_held", 1, 0, 0, 3'd0, 9'o050, 7'b0001000, 0);
    expect_out("l1_back_to_back", 2, 1, 0, 3'd1, 9'o042, 7'b0001000, 0);
    step();
    xct_done = 1'b0;
    xct_held = 1'b0;
    step();
    pi_req   = 7'b0000000;
    ebox_ack = 1'b1;
    expect_out("l1_ack", 1, 0, 1, 3'd1, 9'o042, 7'b0001000, 0);
    step();
    ebox_ack = 1'b0;
    xct_done = 1'b1;
    xct_held = 1'b1;
    expect_out("l1_done_held", 1, 0, 0, 3'd0, 9'o042, 7'b1001000, 0);
    step();
    xct_done = 1'b0;
    xct_held = 1'b0;
    dismiss  = 1'b1;
    expect_out("dismiss_l1_only", 1, 0, 0, 3'd0, 9'o042, 7'b0001000, 0);
    step();
    dismiss = 1'b0;
    // Stray ack/done in IDLE must be ignored.
    ebox_ack = 1'b1;
    xct_done = 1'b1;
    xct_held = 1'b1;
    step();
    ebox_ack = 1'b0;
    xct_done = 1'b0;
    xct_held = 1'b0;
    dismiss  = 1'b1;
    expect_out("dismiss_l4", 1, 0, 0, 3'd0, 9'o042, 7'b0000000, 0);
    step();
    step();  // dismiss with nothing held: no-op
    dismiss = 1'b0;

    // Timeout: no xct_done for 255 cycles in CYCLE.
    pi_req = 7'b0000010;
    expect_out("l6_req", 1, 1, 0, 3'd6, 9'o054, 7'b0000000, 0);
    step();
    pi_req   = 7'b0000000;
    ebox_ack = 1'b1;
    expect_out("l6_ack", 1, 0, 1, 3'd6, 9'o054, 7'b0000000, 0);
    expect_out("timeout_err", 256, 0, 0, 3'd0, 9'o054, 7'b0000000, 1);
    expect_out("timeout_err_end", 257, 0, 0, 3'd0, 9'o054, 7'b0000000, 0);
    step();
    ebox_ack = 1'b0;
    repeat (258) step();

    // Same-edge dismiss and done-held: dismiss sees the old set, then the hold lands.
    pi_req = 7'b0000010;
    expect_out("l6b_req", 1, 1, 0, 3'd6, 9'o054, 7'b0000000, 0);
    step();
    pi_req   = 7'b0000000;
    ebox_ack = 1'b1;
    expect_out("l6b_ack", 1, 0, 1, 3'd6, 9'o054, 7'b0000000, 0);
    step();
    ebox_ack = 1'b0;
    xct_done = 1'b1;
    xct_held = 1'b1;
    expect_out("l6b_done_held", 1, 0, 0, 3'd0, 9'o054, 7'b0000010, 0);
    step();
    xct_done = 1'b0;
    xct_held = 1'b0;
    pi_req   = 7'b0010000;
    expect_out("l3b_req", 1, 1, 0, 3'd3, 9'o046, 7'b0000010, 0);
    step();
    pi_req   = 7'b0000000;
    ebox_ack = 1'b1;
    expect_out("l3b_ack", 1, 0, 1, 3'd3, 9'o046, 7'b0000010, 0);
    step();
    ebox_ack = 1'b0;
    step();
    xct_done = 1'b1;
    xct_held = 1'b1;
    dismiss  = 1'b1;
    expect_out("same_edge_dismiss_hold", 1, 0, 0, 3'd0, 9'o046, 7'b0010000, 0);
    step();
    xct_done = 1'b0;
    xct_held = 1'b0;
    dismiss  = 1'b0;

    // Reset during CYCLE; pending level 5 re-arbitrates once re-enabled.
    pi_req = 7'b0100100;
    expect_out("l2c_req", 1, 1, 0, 3'd2, 9'o044, 7'b0010000, 0);
    step();
    pi_req   = 7'b0000100;
    ebox_ack = 1'b1;
    expect_out("l2c_ack", 1, 0, 1, 3'd2, 9'o044, 7'b0010000, 0);
    step();
    ebox_ack = 1'b0;
    step();
    rst_n = 1'b0;
    expect_out("async_reset", 0, 0, 0, 3'd0, 9'o000, 7'b0000000, 0);
    pi_on = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (3) step();  // pi_on low: no arbitration
    pi_on = 1'b1;
    expect_out("l5_after_reset", 1, 1, 0, 3'd5, 9'o052, 7'b0000000, 0);
    step();
    pi_req   = 7'b0000000;
    ebox_ack = 1'b1;
    expect_out("l5r_ack", 1, 0, 1, 3'd5, 9'o052, 7'b0000000, 0);
    step();
    ebox_ack = 1'b0;
    xct_done = 1'b1;
    expect_out("l5r_done", 1, 0, 0, 3'd0, 9'o052, 7'b0000000, 0);
    step();
    xct_done = 1'b0;
    repeat (4) step();

    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_expectations: got %0d outstanding, required 0 (next %s)",
               exp_q.size(), name_q[0]);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
